rob_cdb_sink: RTL and testbench

Reorder-buffer writeback/commit block at the receiving end of the common data bus (CDB). It allocates in-order entries for issued instructions, captures CDB broadcasts (valid, tag, data) into the entry named by the tag, and retires completed entries in program order to the register file. Reservation stations read captured results through a combinational operand-query port.

---
 rtl/rob_cdb_sink_if.sv | 38 +++
 rtl/rob_cdb_sink.sv | 119 +++++++++++
 tb/tb_rob_cdb_sink.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rob_cdb_sink_if.sv
// Bundles the ROB's allocate, CDB capture, operand-query, commit and status signals.
// master = issue/CDB/RS side driving the ROB; slave = the ROB itself.
// Handshake: alloc_valid/alloc_ready for allocation; CDB and commit are valid-only pulses.
interface rob_cdb_sink_if #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              flush;
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_dest;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  rs_tag;
    logic              rs_hit;
    logic [DATA_W-1:0] rs_data;
    logic              commit_valid;
    logic [REG_W-1:0]  commit_dest;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic [TAG_W:0]    count;
    logic              cdb_err;

    modport master (
        output flush, alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, rs_tag,
        input  alloc_ready, alloc_tag, rs_hit, rs_data,
        input  commit_valid, commit_dest, commit_data, commit_tag, count, cdb_err
    );

    modport slave (
        input  flush, alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, rs_tag,
        output alloc_ready, alloc_tag, rs_hit, rs_data,
        output commit_valid, commit_dest, commit_data, commit_tag, count, cdb_err
    );
endinterface

// File: rtl/rob_cdb_sink.sv
// Reorder buffer sink: in-order alloc, CDB capture by tag, in-order retire to the register file.
// Latency: capture-to-commit_valid 2 cycles (1 cycle with CDB_BYPASS_EN defined, for CDB hitting head).
// Backpressure: alloc_ready drops when all 2^TAG_W entries are occupied; CDB and commit never stall.
module rob_cdb_sink #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    rob_cdb_sink_if.slave      rob
);
    localparam int DEPTH = 1 << TAG_W;
    localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            ent_q [DEPTH];
    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;
    logic              commit_valid_q;
    logic [REG_W-1:0]  commit_dest_q;
    logic [DATA_W-1:0] commit_data_q;
    logic [TAG_W-1:0]  commit_tag_q;
    logic              cdb_err_q;

    logic              alloc_fire;
    logic              cdb_hit;
    logic              cdb_bad;
    logic              bypass_fire;
    logic              commit_fire;
    logic              commit_any;
    logic              capture_fire;
    logic [DATA_W-1:0] commit_data_d;

    assign rob.alloc_ready = (count_q != CNT_FULL);
    assign rob.alloc_tag   = tail_q;
    assign alloc_fire      = rob.alloc_valid && rob.alloc_ready;

    assign cdb_hit = rob.cdb_valid && ent_q[rob.cdb_tag].busy && !ent_q[rob.cdb_tag].ready;
    assign cdb_bad = rob.cdb_valid && !cdb_hit;

    // A CDB result for the head entry can retire straight off the bus, skipping storage.
`ifdef CDB_BYPASS_EN
    assign bypass_fire = cdb_hit && (rob.cdb_tag == head_q);
`else
    assign bypass_fire = 1'b0;
`endif

    assign commit_fire   = ent_q[head_q].busy && ent_q[head_q].ready;
    assign commit_any    = commit_fire || bypass_fire;
    assign capture_fire  = cdb_hit && !bypass_fire;
    assign commit_data_d = bypass_fire ? rob.cdb_data : ent_q[head_q].data;

    // Operand query sees registered state only; stations snoop the CDB themselves.
    assign rob.rs_hit  = ent_q[rob.rs_tag].busy && ent_q[rob.rs_tag].ready;
    assign rob.rs_data = rob.rs_hit ? ent_q[rob.rs_tag].data : '0;

    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_dest  = commit_dest_q;
    assign rob.commit_data  = commit_data_q;
    assign rob.commit_tag   = commit_tag_q;
    assign rob.count        = count_q;
    assign rob.cdb_err      = cdb_err_q;

    always_ff @(posedge clk) begin
        if (rst || rob.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_dest_q  <= '0;
            commit_data_q  <= '0;
            commit_tag_q   <= '0;
        end else begin
            commit_valid_q <= commit_any;
            if (commit_any) begin
                commit_dest_q      <= ent_q[head_q].dest;
                commit_data_q      <= commit_data_d;
                commit_tag_q       <= head_q;
                ent_q[head_q].busy  <= 1'b0;
                ent_q[head_q].ready <= 1'b0;
                head_q             <= head_q + TAG_W'(1);
            end
            // Alloc never targets head (full refuses) and capture never targets a ready head.
            if (capture_fire) begin
                ent_q[rob.cdb_tag].ready <= 1'b1;
                ent_q[rob.cdb_tag].data  <= rob.cdb_data;
            end
            if (alloc_fire) begin
                ent_q[tail_q] <= '{busy: 1'b1, ready: 1'b0, dest: rob.alloc_dest, data: '0};
                tail_q        <= tail_q + TAG_W'(1);
            end
            unique case ({alloc_fire, commit_any})
                2'b10:   count_q <= count_q + (TAG_W+1)'(1);
                2'b01:   count_q <= count_q - (TAG_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Error flag survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_err_q <= 1'b0;
        end else if (cdb_bad) begin
            cdb_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rob_cdb_sink.sv
// Self-checking bench for rob_cdb_sink: directed scenarios then randomized traffic,
// checked every cycle against a program-order queue model of the reorder buffer.
module tb_rob_cdb_sink;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_cdb_sink_if #(.TAG_W(3), .DATA_W(32), .REG_W(5)) bus ();

    rob_cdb_sink #(.TAG_W(3), .DATA_W(32), .REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .rob (bus.slave)
    );

    typedef struct {
        logic [2:0]  tag;
        logic [4:0]  dest;
        bit          done;
        logic [31:0] data;
    } rec_t;

    rec_t        q[$];
    int          next_tag = 0;
    bit          err_m = 0;
    bit          ecv = 0;
    logic [4:0]  edest = '0;
    logic [31:0] edata = '0;
    logic [2:0]  etag = '0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit r, input bit fl, input bit av, input logic [4:0] ad,
                        input bit cv, input logic [2:0] ct, input logic [31:0] cd,
                        input logic [2:0] rt);
        int          n;
        bit          exp_rdy;
        bit          exp_hit;
        logic [31:0] exp_rsd;
        int          hidx;
        bit          good;
        bit          from_head;
        bit          bypass;
        @(negedge clk);
        rst             = r;
        bus.flush       = fl;
        bus.alloc_valid = av;
        bus.alloc_dest  = ad;
        bus.cdb_valid   = cv;
        bus.cdb_tag     = ct;
        bus.cdb_data    = cd;
        bus.rs_tag      = rt;
        #1;
        n       = q.size();
        exp_rdy = (n < 8);
        exp_hit = 0;
        exp_rsd = '0;
        foreach (q[i]) if (q[i].tag == rt && q[i].done) begin exp_hit = 1; exp_rsd = q[i].data; end
        chk("alloc_ready", {31'd0, bus.alloc_ready}, {31'd0, exp_rdy});
        chk("alloc_tag", {29'd0, bus.alloc_tag}, next_tag);
        chk("count", {28'd0, bus.count}, n);
        chk("cdb_err", {31'd0, bus.cdb_err}, {31'd0, err_m});
        chk("rs_hit", {31'd0, bus.rs_hit}, {31'd0, exp_hit});
        chk("rs_data", bus.rs_data, exp_rsd);
        chk("commit_valid", {31'd0, bus.commit_valid}, {31'd0, ecv});
        if (ecv) begin
            chk("commit_dest", {27'd0, bus.commit_dest}, {27'd0, edest});
            chk("commit_data", bus.commit_data, edata);
            chk("commit_tag", {29'd0, bus.commit_tag}, {29'd0, etag});
        end
        hidx = -1;
        foreach (q[i]) if (q[i].tag == ct) hidx = i;
        good = 0;
        if (cv && hidx >= 0) good = !q[hidx].done;
        if (cv && !good) err_m = 1;
        ecv = 0;
        if (r || fl) begin
            q.delete();
            next_tag = 0;
            if (r) err_m = 0;
        end else begin
            from_head = (n > 0) && q[0].done;
            bypass = 0;
`ifdef CDB_BYPASS_EN
            bypass = good && (hidx == 0);
`endif
            if (good && !bypass) begin
                q[hidx].done = 1;
                q[hidx].data = cd;
            end
            if (from_head || bypass) begin
                ecv   = 1;
                edest = q[0].dest;
                edata = bypass ? cd : q[0].data;
                etag  = q[0].tag;
                void'(q.pop_front());
            end
            if (av && exp_rdy) begin
                q.push_back('{tag: 3'(next_tag), dest: ad, done: 0, data: '0});
                next_tag = (next_tag + 1) % 8;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int k, input logic [2:0] rt);
        for (int i = 0; i < k; i++) step(0, 0, 0, 5'd0, 0, 3'd0, 32'd0, rt);
    endtask

    task automatic do_alloc(input logic [4:0] ad);
        step(0, 0, 1, ad, 0, 3'd0, 32'd0, 3'd0);
    endtask

    task automatic do_cdb(input logic [2:0] ct, input logic [31:0] cd);
        step(0, 0, 0, 5'd0, 1, ct, cd, 3'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 5'd0, 0, 3'd0, 32'd0, 3'd0);
    endtask

    initial begin
        logic [2:0] ct;
        bus.flush = 0; bus.alloc_valid = 0; bus.alloc_dest = '0;
        bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0; bus.rs_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk("rst_alloc_tag", {29'd0, bus.alloc_tag}, 32'd0);
        chk("rst_count", {28'd0, bus.count}, 32'd0);
        chk("rst_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
        chk("rst_cdb_err", {31'd0, bus.cdb_err}, 32'd0);

        // Single instruction round trip.
        do_alloc(5'd5);
        do_cdb(3'd0, 32'hDEADBEEF);
        idle(4, 3'd0);

        // Out-of-order completion, in-order retire.
        do_reset();
        do_alloc(5'd1); do_alloc(5'd2); do_alloc(5'd3);
        do_cdb(3'd2, 32'h2222); do_cdb(3'd1, 32'h1111); do_cdb(3'd0, 32'h0000_0AAA);
        idle(5, 3'd2);

        // Fill, refused ninth alloc, drain one, wrap.
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(5'(i + 10));
        do_alloc(5'd31);
        do_cdb(3'd0, 32'hCAFE0000);
        idle(3, 3'd0);
        do_alloc(5'd7);
        idle(1, 3'd0);

        // Bad CDB writes: unallocated tag and duplicate to a ready entry.
        do_reset();
        do_alloc(5'd4); do_alloc(5'd6);
        do_cdb(3'd6, 32'h6666);
        do_cdb(3'd1, 32'h1);
        do_cdb(3'd1, 32'h2);
        idle(4, 3'd1);

        // Operand query before and after capture.
        do_reset();
        do_alloc(5'd8); do_alloc(5'd9);
        idle(1, 3'd1);
        do_cdb(3'd1, 32'h1234);
        idle(2, 3'd1);

        // Flush with concurrent alloc and CDB.
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(5'(i + 1));
        step(0, 1, 1, 5'd20, 1, 3'd1, 32'h5555, 3'd0);
        idle(3, 3'd0);

        // Reset while a commit is pending.
        do_alloc(5'd3); do_alloc(5'd4);
        do_cdb(3'd0, 32'h77);
        do_reset();
        idle(3, 3'd0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if (q.size() > 0 && $urandom_range(3) != 0) ct = q[$urandom_range(q.size() - 1)].tag;
            else ct = 3'($urandom);
            step($urandom_range(99) == 0, $urandom_range(49) == 0,
                 $urandom_range(1) == 1, 5'($urandom),
                 $urandom_range(2) != 0, ct, $urandom, 3'($urandom));
        end
        idle(3, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
